// File: rtl/sram_responder_if.sv
// Request/response port between an initiator (IFU/LSU) and the SRAM responder.
// A transfer happens on the rising edge where valid and ready are both high; valid and its payload are held until that edge.
interface sram_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_wen;
   logic [31:0] req_wdata;
   logic [3:0]  req_wmask;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/sram_responder.sv
// Word-addressed SRAM responder: one outstanding request, response after LATENCY cycles,
// held until the initiator takes it.
module sram_responder #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter int          LATENCY    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   sram_responder_if.slave         s_bus,
   output logic [1:0]              o_dbg_state
);
   localparam int          DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [32:0] SPAN   = 33'd4 << DEPTH_LOG2;
   localparam logic [3:0]  LAT_M2 = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state, w_next;
   logic [3:0]  r_cnt, w_cnt_next;
   logic [31:0] r_addr, r_wdata;
   logic        r_wen;
   logic [3:0]  r_wmask;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] r_mem [0:DEPTH-1];

   logic                  w_req_ready, w_accept, w_commit, w_in_range;
   logic [31:0]           w_src_addr, w_src_wdata, w_off;
   logic                  w_src_wen;
   logic [3:0]            w_src_wmask;
   logic [DEPTH_LOG2-1:0] w_idx;

   assign w_req_ready = (r_state == S_IDLE) && !rst;
   assign w_accept    = s_bus.req_valid && w_req_ready;

   // With LATENCY==1 the commit edge is the acceptance edge, so the live request is used.
   assign w_src_addr  = (r_state == S_IDLE) ? s_bus.req_addr  : r_addr;
   assign w_src_wen   = (r_state == S_IDLE) ? s_bus.req_wen   : r_wen;
   assign w_src_wdata = (r_state == S_IDLE) ? s_bus.req_wdata : r_wdata;
   assign w_src_wmask = (r_state == S_IDLE) ? s_bus.req_wmask : r_wmask;

   assign w_off      = w_src_addr - BASE_ADDR;
   assign w_in_range = {1'b0, w_off} < SPAN;
   assign w_idx      = w_off[DEPTH_LOG2+1:2];

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (LATENCY == 1) begin
                  w_next = S_RESP;
               end else begin
                  w_next     = S_BUSY;
                  w_cnt_next = LAT_M2;
               end
            end
         end
         S_BUSY: begin
            if (r_cnt == 4'd0) w_next = S_RESP;
            else               w_cnt_next = r_cnt - 4'd1;
         end
         S_RESP: begin
            if (s_bus.resp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_commit = !rst && (w_next == S_RESP) && (r_state != S_RESP);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_commit) begin
            r_err   <= !w_in_range;
            r_rdata <= (w_src_wen || !w_in_range) ? 32'd0 : r_mem[w_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr  <= s_bus.req_addr;
         r_wen   <= s_bus.req_wen;
         r_wdata <= s_bus.req_wdata;
         r_wmask <= s_bus.req_wmask;
      end
   end

   always_ff @(posedge clk) begin
      if (w_commit && w_src_wen && w_in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (w_src_wmask[i]) r_mem[w_idx][8*i +: 8] <= w_src_wdata[8*i +: 8];
         end
      end
   end

   assign s_bus.req_ready  = w_req_ready;
   assign s_bus.resp_valid = (r_state == S_RESP);
   assign s_bus.resp_rdata = r_rdata;
   assign s_bus.resp_err   = r_err;
   assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_sram_responder.sv
// Randomized bench for sram_responder: one LATENCY=1 and one LATENCY=4 instance driven
// through a shared stimulus bus, checked against a transaction-level memory model.
module tb_sram_responder;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_responder_if if1 ();
   sram_responder_if if4 ();
   logic [1:0] dbg1, dbg4;

   sram_responder #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .s_bus(if1.slave), .o_dbg_state(dbg1));
   sram_responder #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(4)) u_dut4 (
      .clk(clk), .rst(rst), .s_bus(if4.slave), .o_dbg_state(dbg4));

   // sel picks which instance the shared stimulus talks to
   int          sel = 0;
   logic        req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_wmask = '0;

   assign if1.req_valid  = (sel == 0) ? req_valid : 1'b0;
   assign if4.req_valid  = (sel == 1) ? req_valid : 1'b0;
   assign if1.resp_ready = (sel == 0) ? resp_ready : 1'b0;
   assign if4.resp_ready = (sel == 1) ? resp_ready : 1'b0;
   assign if1.req_addr   = req_addr;   assign if4.req_addr  = req_addr;
   assign if1.req_wen    = req_wen;    assign if4.req_wen   = req_wen;
   assign if1.req_wdata  = req_wdata;  assign if4.req_wdata = req_wdata;
   assign if1.req_wmask  = req_wmask;  assign if4.req_wmask = req_wmask;

   logic        w_req_ready, w_resp_valid, w_resp_err;
   logic [31:0] w_resp_rdata;
   assign w_req_ready  = (sel == 1) ? if4.req_ready  : if1.req_ready;
   assign w_resp_valid = (sel == 1) ? if4.resp_valid : if1.resp_valid;
   assign w_resp_err   = (sel == 1) ? if4.resp_err   : if1.resp_err;
   assign w_resp_rdata = (sel == 1) ? if4.resp_rdata : if1.resp_rdata;

   // Reference model: one word array per instance, expected responses queued as {err, rdata}
   logic [31:0] mdl [0:1][0:1023];
   logic [32:0] exp_q [$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
      end
   endtask

   function automatic logic [32:0] model_txn(input logic [31:0] a, input logic wen,
                                             input logic [31:0] wd, input logic [3:0] wm);
      logic [31:0] off, word;
      int          idx;
      off = a - BASE;
      if (off >= 32'd4096) return {1'b1, 32'd0};
      idx = int'(off >> 2);
      if (!wen) return {1'b0, mdl[sel][idx]};
      word = mdl[sel][idx];
      for (int b = 0; b < 4; b++) if (wm[b]) word[8*b +: 8] = wd[8*b +: 8];
      mdl[sel][idx] = word;
      return {1'b0, 32'd0};
   endfunction

   task automatic do_txn(input logic [31:0] a, input logic wen, input logic [31:0] wd,
                         input logic [3:0] wm, input int hold, input bit junk,
                         output logic [31:0] rd_out);
      logic [32:0] exp, got;
      int n, lat, lat_exp;
      lat_exp = (sel == 1) ? 4 : 1;
      exp_q.push_back(model_txn(a, wen, wd, wm));
      @(negedge clk);
      req_valid = 1'b1; req_addr = a; req_wen = wen; req_wdata = wd; req_wmask = wm;
      resp_ready = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      n = 0;
      while (w_req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) check("req_ready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (w_resp_valid !== 1'b1 && lat < 40) begin
         check("req_ready_low_busy", 64'(w_req_ready), 64'd0);
         if (junk) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_addr   = $urandom; req_wen = 1'($urandom_range(0, 1));
            req_wdata  = $urandom; req_wmask = 4'($urandom_range(0, 15));
            resp_ready = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
         lat++;
      end
      req_valid = 1'b0;
      check("latency", 64'(lat), 64'(lat_exp));
      check("req_ready_low_resp", 64'(w_req_ready), 64'd0);
      got = {w_resp_err, w_resp_rdata};
      exp = exp_q.pop_front();
      check("resp_data", 64'(got), 64'(exp));
      rd_out = w_resp_rdata;
      for (int h = 0; h < hold; h++) begin
         resp_ready = 1'b0;
         @(posedge clk); #1;
         check("hold_valid", 64'(w_resp_valid), 64'd1);
         check("hold_data", 64'({w_resp_err, w_resp_rdata}), 64'(got));
         check("hold_req_ready", 64'(w_req_ready), 64'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("release_valid", 64'(w_resp_valid), 64'd0);
      check("release_req_ready", 64'(w_req_ready), 64'd1);
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return BASE - 32'(4 * $urandom_range(1, 64)) + 32'($urandom_range(0, 3));
         1:       return BASE + 32'h1000 + 32'($urandom_range(0, 255));
         default: return BASE + {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
      endcase
   endfunction

   logic [31:0] rd, old_val;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 64'({if1.req_ready, if4.req_ready}), 64'd0);
      check("rst_resp_valid", 64'({if1.resp_valid, if4.resp_valid}), 64'd0);
      check("rst_rdata", 64'({if1.resp_rdata, if4.resp_rdata}), 64'd0);
      check("rst_err", 64'({if1.resp_err, if4.resp_err}), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int s = 0; s < 2; s++) begin
         sel = s;
         for (int i = 0; i < 1024; i++) do_txn(BASE + 32'(4 * i), 1'b1, $urandom, 4'hF, 0, 0, rd);
      end

      sel = 0;
      do_txn(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 0, rd);
      do_txn(32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 0, rd);
      check("rd_deadbeef", 64'(rd), 64'h0000_0000_DEAD_BEEF);
      do_txn(32'h8000_0000, 1'b1, 32'h1122_3344, 4'hF, 0, 0, rd);
      do_txn(32'h8000_0000, 1'b1, 32'hAABB_CCDD, 4'b0101, 0, 0, rd);
      do_txn(32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 0, rd);
      check("rd_bytemask", 64'(rd), 64'h0000_0000_11BB_33DD);
      do_txn(32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 4'h0, 0, 0, rd);
      do_txn(32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 0, rd);
      check("rd_mask0", 64'(rd), 64'h0000_0000_11BB_33DD);
      do_txn(32'h8000_1000, 1'b0, 32'h0, 4'h0, 0, 0, rd);
      do_txn(32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 0, 0, rd);
      do_txn(32'h8000_0FFC, 1'b1, 32'h0BAD_F00D, 4'hF, 0, 0, rd);
      do_txn(32'h8000_0FFC, 1'b0, 32'h0, 4'h0, 0, 0, rd);
      check("rd_word1023", 64'(rd), 64'h0000_0000_0BAD_F00D);

      sel = 1;
      do_txn(32'h8000_0010, 1'b0, 32'h0, 4'h0, 5, 1, rd);
      do_txn(32'h8000_0020, 1'b1, 32'h1234_5678, 4'hF, 0, 1, rd);
      do_txn(32'h8000_0020, 1'b0, 32'h0, 4'h0, 2, 1, rd);
      check("rd_lat4_raw", 64'(rd), 64'h0000_0000_1234_5678);

      for (int s = 0; s < 2; s++) begin
         sel = s;
         for (int i = 0; i < 200; i++)
            do_txn(rand_addr(), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), 1, rd);
      end

      // Write interrupted by reset while still in BUSY must not land
      sel = 1;
      old_val = mdl[1][16];
      @(negedge clk);
      req_valid = 1'b1; req_addr = BASE + 32'h40; req_wen = 1'b1;
      req_wdata = ~old_val; req_wmask = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("midrst_resp_valid", 64'(w_resp_valid), 64'd0);
         check("midrst_req_ready", 64'(w_req_ready), 64'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      do_txn(BASE + 32'h40, 1'b0, 32'h0, 4'h0, 0, 0, rd);
      check("midrst_old_value", 64'(rd), 64'(old_val));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the core's fetch/load-store request port. It is the slave end of the same valid/ready handshake the IFU and LSU drive as initiators.
- Holds a word-addressed on-chip SRAM array and accepts one read or write request at a time.
- Returns the response after a programmable latency and holds it until the initiator takes it.
- Lets IFU/LSU multi-cycle behaviour be exercised without the simulator memory path.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words in the array.
- BASE_ADDR, 32'h8000_0000, byte address mapped to word 0.
- LATENCY, 1, cycles from request acceptance to resp_valid. Legal values are 1..15; 0 is illegal.

Ports:
- clk  in  1  clock, all logic on the rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  initiator presents a request
- req_ready  out  1  responder can accept a request
- req_addr  in  32  byte address; bits [1:0] are ignored
- req_wen  in  1  1 = write, 0 = read
- req_wdata  in  32  write data
- req_wmask  in  4  byte enables; bit i enables byte i
- resp_valid  out  1  response available
- resp_ready  in  1  initiator takes the response
- resp_rdata  out  32  read data; 0 for writes and errors
- resp_err  out  1  address was out of range

Behaviour:
- Reset:
  - state=IDLE, req_ready=0 while rst is high, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - The array is not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1 (when rst=0).
  - On req_valid & req_ready at edge E0, latch addr, wen, wdata and wmask.
  - If LATENCY==1, go to RESP; otherwise go to BUSY with counter=LATENCY-2.
- BUSY:
  - req_ready=0.
  - Counter decrements each edge; when it is 0 at an edge, go to RESP.
- Commit happens at the edge entering RESP:
  - In range, read: resp_rdata=mem[idx], resp_err=0.
  - In range, write: each byte i with wmask[i]=1 is written into mem[idx]; resp_rdata=0, resp_err=0.
  - Out of range: no array access, resp_rdata=0, resp_err=1.
- Timing: resp_valid rises exactly LATENCY cycles after E0.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are stable.
  - req_ready=0.
  - On resp_valid & resp_ready, return to IDLE. req_ready is high again in the following cycle.
- Only one request is outstanding. Minimum request spacing is LATENCY+1 cycles when resp_ready is held high.
- Address decode:
  - off = req_addr - BASE_ADDR, computed modulo 2^32.
  - In range iff off < 4*2^DEPTH_LOG2.
  - idx = off[DEPTH_LOG2+1:2].
  - A request wrapping below BASE_ADDR yields a large off and is therefore an error.
- Write mask cases:
  - wmask=0 on a write: no bytes change, response still returned.
  - Full-word writes use 4'hF.
- Read-after-write to the same idx in consecutive transactions returns the new data.
- resp_ready high before resp_valid has no effect. resp_ready held low keeps RESP indefinitely.
- req_valid while not ready is ignored. Its fields are not sampled.
- Reset mid-operation: rst in BUSY or RESP returns to IDLE and drops resp_valid in the next cycle. A write still in BUSY is never committed; one already in RESP stays committed.

Test Plan:
- LATENCY=1:
  - Write 0x8000_0010 data 0xDEADBEEF mask 4'hF, then read 0x8000_0010 → rdata 0xDEADBEEF, err=0.
  - resp_valid rises 1 cycle after each acceptance.
- Byte-mask write:
  - Preload word 0 with 0x11223344, then write 0xAABBCCDD with mask 4'b0101.
  - Read → 0x11BB33DD.
- LATENCY=4:
  - Read accepted at cycle 10 → resp_valid first high at cycle 14.
  - req_ready low in cycles 11–14 (while in BUSY/RESP).
  - req_valid pulses during BUSY are ignored.
- Backpressure:
  - Hold resp_ready=0 for 5 cycles after resp_valid → rdata/err stable, resp_valid stays 1, req_ready=0.
  - Release → IDLE next cycle.
- Range errors (DEPTH_LOG2=10):
  - Read 0x8000_1000 → err=1, rdata=0.
  - Read 0x7FFF_FFFC → err=1.
  - Write 0x8000_0FFC → err=0 and the write lands in word 1023.
- Reset mid-operation (LATENCY=4):
  - Write accepted, rst asserted 2 cycles later → resp_valid=0 and req_ready=0 during reset.
  - After release, read of that address returns the old value.
